branch_predictor: RTL and testbench

- Fetch-stage branch predictor with a direct-mapped BTB of 2-bit saturating counters.
- Resolves predictions against execute-stage outcomes.
- Produces the pipeline flush/redirect `rst_out`, the signal the CPU testbenches count as mispredictions.
- Sits between the fetch PC mux and the execute stage. Also keeps an internal saturating misprediction counter for self-checking runs.

---
 rtl/bp_pkg.sv | 28 ++
 rtl/sat_counter2.sv | 19 +
 rtl/branch_predictor.sv | 124 ++++++++++++
 tb/tb_branch_predictor.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and sizing helpers for the fetch-stage branch predictor.
package bp_pkg;

  localparam int BP_ADDR_W     = 32;
  localparam int BP_INDEX_BITS = 6;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  function automatic int tag_w(input int aw, input int ib);
    return aw - ib - 2;
  endfunction

  function automatic int num_entries(input int ib);
    return 1 << ib;
  endfunction

  // Entry layout at the default geometry.
  typedef struct packed {
    logic                                          valid;
    logic [tag_w(BP_ADDR_W, BP_INDEX_BITS)-1:0]    tag;
    logic [BP_ADDR_W-1:0]                          target;
    logic [1:0]                                    ctr;
  } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// Two-bit saturating counter next-state function.
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_taken,
  output logic [1:0] o_ctr
);

  always_comb begin
    o_ctr = i_ctr;
    unique case (1'b1)
      (i_taken && i_ctr != ST):   o_ctr = i_ctr + 2'd1;
      (!i_taken && i_ctr != SNT): o_ctr = i_ctr - 2'd1;
      default:                    o_ctr = i_ctr;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; resolves execute outcomes
// and issues a registered one-cycle flush with redirect PC.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int INDEX_BITS = 6,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_BF,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              ex_pred_taken,
  input  logic [ADDR_W-1:0] ex_pred_target,
  output logic              rst_out,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  mispredict_count
);

  localparam int TAG_W = tag_w(ADDR_W, INDEX_BITS);
  localparam int N     = num_entries(INDEX_BITS);

  logic              r_valid  [N];
  logic [TAG_W-1:0]  r_tag    [N];
  logic [ADDR_W-1:0] r_target [N];
  logic [1:0]        r_ctr    [N];

  logic              r_rst_out;
  logic [ADDR_W-1:0] r_redirect;
  logic [CNT_W-1:0]  r_count;

  logic [INDEX_BITS-1:0] w_fidx;
  logic [TAG_W-1:0]      w_ftag;
  logic                  w_fhit;
  logic                  w_ptaken;

  logic [INDEX_BITS-1:0] w_eidx;
  logic [TAG_W-1:0]      w_etag;
  logic                  w_ehit;
  logic                  w_upd;
  logic                  w_mis;
  logic                  w_tgt_bad;
  logic [1:0]            w_ctr_nxt;
  logic [ADDR_W-1:0]     w_fall;
  logic                  w_unused;

  assign w_unused = ^{fetch_pc[1:0], ex_pc[1:0]};

  // Fetch-side lookup reads registered state only (read-before-write).
  assign w_fidx   = fetch_pc[INDEX_BITS+1:2];
  assign w_ftag   = fetch_pc[ADDR_W-1:INDEX_BITS+2];
  assign w_fhit   = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
  assign w_ptaken = w_fhit && r_ctr[w_fidx][1];

  assign pred_taken  = w_ptaken;
  assign pred_target = w_ptaken ? r_target[w_fidx]
                                : fetch_pc + ADDR_W'(4);

  assign w_eidx    = ex_pc[INDEX_BITS+1:2];
  assign w_etag    = ex_pc[ADDR_W-1:INDEX_BITS+2];
  assign w_ehit    = r_valid[w_eidx] && (r_tag[w_eidx] == w_etag);
  assign w_upd     = ex_valid && ex_is_branch;
  assign w_fall    = ex_pc + ADDR_W'(4);
  assign w_tgt_bad = ex_taken && ex_pred_taken
                     && (ex_target != ex_pred_target);
  assign w_mis     = w_upd
                     && ((ex_taken != ex_pred_taken) || w_tgt_bad);

  sat_counter2 u_ctr (
    .i_ctr   (r_ctr[w_eidx]),
    .i_taken (ex_taken),
    .o_ctr   (w_ctr_nxt)
  );

  always_ff @(posedge clk or posedge rst_BF) begin
    if (rst_BF) begin
      for (int i = 0; i < N; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= WNT;
      end
    end else if (w_upd) begin
      if (w_ehit) begin
        r_ctr[w_eidx] <= w_ctr_nxt;
        if (ex_taken)
          r_target[w_eidx] <= ex_target;
      end else if (ex_taken) begin
        r_valid[w_eidx]  <= 1'b1;
        r_tag[w_eidx]    <= w_etag;
        r_target[w_eidx] <= ex_target;
        r_ctr[w_eidx]    <= WT;
      end
    end
  end

  // Flush pulse is re-evaluated every edge: one cycle per mispredict.
  always_ff @(posedge clk or posedge rst_BF) begin
    if (rst_BF) begin
      r_rst_out  <= 1'b0;
      r_redirect <= '0;
      r_count    <= '0;
    end else begin
      r_rst_out <= w_mis;
      if (w_mis) begin
        r_redirect <= ex_taken ? ex_target : w_fall;
        if (r_count != {CNT_W{1'b1}})
          r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign rst_out          = r_rst_out;
  assign redirect_pc      = r_redirect;
  assign mispredict_count = r_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed scenarios plus random traffic
// against an array-based reference of the predictor's rules.
module tb_branch_predictor;

  logic        clk;
  logic        rst_BF;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        rst_out;
  logic [31:0] redirect_pc;
  logic [31:0] mcount;

  logic        s_pred_taken;
  logic [31:0] s_pred_target;
  logic        s_rst_out;
  logic [31:0] s_redirect_pc;
  logic [3:0]  s_mcount;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: one slot per index, plain integers.
  bit          m_valid [64];
  int unsigned m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_ctr   [64];
  bit          e_rst;
  logic [31:0] e_redir;
  longint      e_cnt;

  branch_predictor #(.ADDR_W(32), .INDEX_BITS(6), .CNT_W(32)) dut (
    .clk(clk), .rst_BF(rst_BF), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .rst_out(rst_out), .redirect_pc(redirect_pc),
    .mispredict_count(mcount)
  );

  branch_predictor #(.ADDR_W(32), .INDEX_BITS(6), .CNT_W(4)) dut_s (
    .clk(clk), .rst_BF(rst_BF), .fetch_pc(fetch_pc),
    .pred_taken(s_pred_taken), .pred_target(s_pred_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .rst_out(s_rst_out), .redirect_pc(s_redirect_pc),
    .mispredict_count(s_mcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 1;
    end
    e_rst   = 0;
    e_redir = '0;
    e_cnt   = 0;
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == (pc >> 8));
  endfunction

  function automatic bit m_pt(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptg(input logic [31:0] pc);
    return m_pt(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
  endfunction

  // One clock: check lookup before the edge, outputs after it.
  task automatic tick();
    bit upd, mis;
    int k;
    longint sc;
    #1;
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, m_pt(fetch_pc)});
    chk("pred_target", pred_target, m_ptg(fetch_pc));
    upd = ex_valid && ex_is_branch;
    mis = upd && ((ex_taken != ex_pred_taken) ||
          (ex_taken && ex_pred_taken && ex_target != ex_pred_target));
    e_rst = mis;
    if (mis) begin
      e_redir = ex_taken ? ex_target : ex_pc + 32'd4;
      e_cnt++;
    end
    if (upd) begin
      k = idx_of(ex_pc);
      if (m_hit(ex_pc)) begin
        if (ex_taken) begin
          m_ctr[k] = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
          m_tgt[k] = ex_target;
        end else begin
          m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
        end
      end else if (ex_taken) begin
        m_valid[k] = 1;
        m_tag[k]   = ex_pc >> 8;
        m_tgt[k]   = ex_target;
        m_ctr[k]   = 2;
      end
    end
    @(posedge clk);
    #1;
    sc = (e_cnt > 15) ? 15 : e_cnt;
    chk("rst_out", {31'd0, rst_out}, {31'd0, e_rst});
    chk("redirect_pc", redirect_pc, e_redir);
    chk("count", mcount, e_cnt[31:0]);
    chk("count_sat4", {28'd0, s_mcount}, sc[31:0]);
  endtask

  task automatic resolve(input logic [31:0] pc, input bit tk,
                         input logic [31:0] tg, input bit ptk,
                         input logic [31:0] ptg);
    ex_valid       = 1'b1;
    ex_is_branch   = 1'b1;
    ex_pc          = pc;
    ex_taken       = tk;
    ex_target      = tg;
    ex_pred_taken  = ptk;
    ex_pred_target = ptg;
    tick();
    ex_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] pcs [8];
    logic [31:0] pc;
    bit tk;
    pcs[0] = 32'h100;  pcs[1] = 32'h200;  pcs[2] = 32'h104;
    pcs[3] = 32'h300;  pcs[4] = 32'h1000_0100;
    pcs[5] = 32'hFFFF_FFFC; pcs[6] = 32'h2F8; pcs[7] = 32'h400;

    rst_BF = 1'b1;
    fetch_pc = 32'h100;
    ex_valid = 0; ex_is_branch = 0; ex_pc = 0; ex_taken = 0;
    ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
    m_reset();
    #12;
    chk("reset_rst_out", {31'd0, rst_out}, 32'd0);
    chk("reset_count", mcount, 32'd0);
    chk("reset_pred", {31'd0, pred_taken}, 32'd0);
    chk("reset_ptgt", pred_target, 32'h104);
    @(posedge clk); #1;
    rst_BF = 1'b0;

    // Cold taken branch
    fetch_pc = 32'h100;
    resolve(32'h100, 1, 32'h80, 0, 32'h0);
    chk("cold_rst_out", {31'd0, rst_out}, 32'd1);
    chk("cold_redirect", redirect_pc, 32'h80);
    chk("cold_count", mcount, 32'd1);
    tick();
    chk("cold_pulse_end", {31'd0, rst_out}, 32'd0);
    chk("cold_pred", {31'd0, pred_taken}, 32'd1);
    chk("cold_ptgt", pred_target, 32'h80);

    // Loop training
    for (int i = 0; i < 5; i++)
      resolve(32'h100, 1, 32'h80, 1, 32'h80);
    chk("train_no_flush", {31'd0, rst_out}, 32'd0);
    chk("train_count", mcount, 32'd1);
    resolve(32'h100, 0, 32'h80, 1, 32'h80);
    chk("nt_flush", {31'd0, rst_out}, 32'd1);
    chk("nt_redirect", redirect_pc, 32'h104);
    #1;
    chk("nt_still_taken", {31'd0, pred_taken}, 32'd1);
    resolve(32'h100, 0, 32'h80, 1, 32'h80);
    #1;
    chk("nt2_not_taken", {31'd0, pred_taken}, 32'd0);

    // Target mismatch (re-train to taken first)
    resolve(32'h100, 1, 32'h80, 0, 32'h0);
    resolve(32'h100, 1, 32'hC0, 1, 32'h80);
    chk("tgt_flush", {31'd0, rst_out}, 32'd1);
    chk("tgt_redirect", redirect_pc, 32'hC0);
    #1;
    chk("tgt_updated", pred_target, 32'hC0);

    // Aliasing: 0x200 shares index 0 with 0x100
    fetch_pc = 32'h200;
    resolve(32'h200, 1, 32'h40, 0, 32'h0);
    fetch_pc = 32'h100;
    #1;
    chk("alias_miss", {31'd0, pred_taken}, 32'd0);
    chk("alias_ptgt", pred_target, 32'h104);
    fetch_pc = 32'h200;
    #1;
    chk("alias_new", pred_target, 32'h40);

    // Mid-cycle asynchronous reset after training
    #2;
    rst_BF = 1'b1;
    #1;
    chk("areset_rst_out", {31'd0, rst_out}, 32'd0);
    chk("areset_count", mcount, 32'd0);
    chk("areset_pred200", {31'd0, pred_taken}, 32'd0);
    fetch_pc = 32'h100;
    #1;
    chk("areset_pred100", {31'd0, pred_taken}, 32'd0);
    m_reset();
    @(posedge clk); #1;
    rst_BF = 1'b0;

    // 20 consecutive mispredicts
    for (int i = 0; i < 20; i++) begin
      resolve(32'h400 + 32'(i * 4), 1, 32'h800, 0, 32'h0);
      chk("sat_pulse", {31'd0, s_rst_out}, 32'd1);
    end
    chk("sat_hold15", {28'd0, s_mcount}, 32'd15);
    chk("sat_full", mcount, 32'd20);
    tick();
    chk("sat_pulse_end", {31'd0, s_rst_out}, 32'd0);

    // Random traffic on a small PC set
    for (int n = 0; n < 400; n++) begin
      pc = pcs[$urandom_range(0, 7)];
      fetch_pc = pcs[$urandom_range(0, 7)];
      tk = $urandom_range(0, 1) == 1;
      ex_valid       = $urandom_range(0, 3) != 0;
      ex_is_branch   = $urandom_range(0, 4) != 0;
      ex_pc          = pc;
      ex_taken       = tk;
      ex_target      = ($urandom_range(0, 1) == 1) ? 32'h80 : 32'h1F0;
      ex_pred_taken  = m_pt(pc);
      ex_pred_target = m_ptg(pc);
      if ($urandom_range(0, 7) == 0)
        ex_pred_taken = ~ex_pred_taken;
      tick();
    end
    ex_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
